// File: rtl/xbar_route_sequencer.sv
// Crossbar configuration sequencer.
// Accepts a full routing map, then walks the columns twice: first breaking stale
// connections, then making new ones. Each toggle address is held for one cycle and
// followed by the rest address, so the crossbar sees every toggle exactly once and
// never finds a column already claimed.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for cfg_valid; AddressSelect at rest
// BREAK_SCAN | inspect column col; toggle out a stale connection if any
// BREAK_REST | one rest cycle after a break toggle
// MAKE_SCAN  | inspect column col; toggle in the target connection if any
// MAKE_REST  | one rest cycle after a make toggle
// DONE       | cfg_done pulse, then back to IDLE
module xbar_route_sequencer #(
    parameter int IP_COUNT   = 3,
    parameter int OP_COUNT   = 3,
    parameter int REST_ADDR  = IP_COUNT * OP_COUNT,
    parameter int ADDR_WIDTH = $clog2(REST_ADDR + 1),
    parameter int SEL_WIDTH  = $clog2(IP_COUNT + 1)
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [OP_COUNT*SEL_WIDTH-1:0]   cfg_map,
    output logic                            cfg_done,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           AddressSelect,
    output logic [OP_COUNT*SEL_WIDTH-1:0]   cur_map
);

    localparam int COL_WIDTH = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1;
    localparam logic [SEL_WIDTH-1:0]  SEL_NONE = SEL_WIDTH'(IP_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ADDR_REST = ADDR_WIDTH'(REST_ADDR);
    localparam logic [COL_WIDTH-1:0]  COL_LAST = COL_WIDTH'(OP_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        BREAK_SCAN,
        BREAK_REST,
        MAKE_SCAN,
        MAKE_REST,
        DONE
    } state_t;

    state_t                                 state_q, state_d;
    logic [COL_WIDTH-1:0]                   col_q, col_d;
    logic [OP_COUNT-1:0][SEL_WIDTH-1:0]     tgt_q, tgt_d;
    logic [OP_COUNT-1:0][SEL_WIDTH-1:0]     cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;

    logic [OP_COUNT-1:0][SEL_WIDTH-1:0]     tgt_norm;
    logic [SEL_WIDTH-1:0]                   cur_sel;
    logic [SEL_WIDTH-1:0]                   tgt_sel;
    logic                                   last_col;
    logic [COL_WIDTH-1:0]                   col_next;

    // Clamp out-of-range selectors to "unconnected" before latching the target.
    always_comb begin
        tgt_norm = '0;
        for (int n = 0; n < OP_COUNT; n++) begin
            if (cfg_map[n*SEL_WIDTH +: SEL_WIDTH] > SEL_NONE) begin
                tgt_norm[n] = SEL_NONE;
            end else begin
                tgt_norm[n] = cfg_map[n*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    // Per-column selectors and column stepping shared by both phases.
    always_comb begin
        cur_sel  = cur_q[col_q];
        tgt_sel  = tgt_q[col_q];
        last_col = (col_q == COL_LAST);
        col_next = last_col ? '0 : col_q + 1'b1;
    end

    // Next-state, shadow update and toggle address generation.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        addr_d  = ADDR_REST;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    tgt_d   = tgt_norm;
                    col_d   = '0;
                    state_d = BREAK_SCAN;
                end
            end
            BREAK_SCAN: begin
                if (cur_sel != SEL_NONE && cur_sel != tgt_sel) begin
                    addr_d       = ADDR_WIDTH'(cur_sel) * ADDR_WIDTH'(OP_COUNT)
                                   + ADDR_WIDTH'(col_q);
                    cur_d[col_q] = SEL_NONE;
                    state_d      = BREAK_REST;
                end else begin
                    col_d   = col_next;
                    state_d = last_col ? MAKE_SCAN : BREAK_SCAN;
                end
            end
            BREAK_REST: begin
                col_d   = col_next;
                state_d = last_col ? MAKE_SCAN : BREAK_SCAN;
            end
            MAKE_SCAN: begin
                if (tgt_sel != SEL_NONE && cur_sel != tgt_sel) begin
                    addr_d       = ADDR_WIDTH'(tgt_sel) * ADDR_WIDTH'(OP_COUNT)
                                   + ADDR_WIDTH'(col_q);
                    cur_d[col_q] = tgt_sel;
                    state_d      = MAKE_REST;
                end else begin
                    col_d   = col_next;
                    state_d = last_col ? DONE : MAKE_SCAN;
                end
            end
            MAKE_REST: begin
                col_d   = col_next;
                state_d = last_col ? DONE : MAKE_SCAN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and address registers; reset matches the crossbar's own reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            tgt_q   <= {OP_COUNT{SEL_NONE}};
            cur_q   <= {OP_COUNT{SEL_NONE}};
            addr_q  <= ADDR_REST;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            addr_q  <= addr_d;
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        cfg_ready     = (state_q == IDLE) && !Rst;
        cfg_done      = (state_q == DONE);
        busy          = (state_q != IDLE);
        AddressSelect = addr_q;
        cur_map       = cur_q;
    end

endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Bench for xbar_route_sequencer: drives directed and random routing maps, models
// the crossbar itself (toggle semantics and column-claim guard) and predicts the
// toggle list, done timing and final shadow from the routing rules directly.
module tb_xbar_route_sequencer;

    localparam int IP = 3;
    localparam int OP = 3;
    localparam int REST = IP * OP;
    localparam int NONE = IP;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_map;
    logic       cfg_done;
    logic       busy;
    logic [3:0] AddressSelect;
    logic [5:0] cur_map;

    int n_cmp = 0;
    int n_mis = 0;

    int  mdl_cur [OP];
    bit  conn [IP][OP];
    int  xbar_rej = 0;

    always #5 Clk = ~Clk;

    xbar_route_sequencer #(.IP_COUNT(IP), .OP_COUNT(OP)) dut (
        .Clk(Clk), .Rst(Rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_map(cfg_map), .cfg_done(cfg_done), .busy(busy),
        .AddressSelect(AddressSelect), .cur_map(cur_map)
    );

    // Behavioural crossbar: each sampled non-rest address toggles one crosspoint,
    // refusing to connect into a column another input already owns.
    always @(posedge Clk or posedge Rst) begin
        int r;
        int c;
        if (Rst) begin
            for (int i = 0; i < IP; i++)
                for (int j = 0; j < OP; j++) conn[i][j] = 1'b0;
        end else if (int'(AddressSelect) < REST) begin
            r = int'(AddressSelect) / OP;
            c = int'(AddressSelect) % OP;
            if (conn[r][c]) begin
                conn[r][c] = 1'b0;
            end else begin
                bit claimed;
                claimed = 1'b0;
                for (int i = 0; i < IP; i++) if (conn[i][c]) claimed = 1'b1;
                if (claimed) xbar_rej++;
                else conn[r][c] = 1'b1;
            end
        end
    end

    function automatic int in_data(input int r);
        return 8'hA0 + r;
    endfunction

    function automatic int xbar_out(input int c);
        int v;
        v = 0;
        for (int r = 0; r < IP; r++) if (conn[r][c]) v = v | in_data(r);
        return v;
    endfunction

    function automatic int mdl_word();
        int w;
        w = 0;
        for (int c = 0; c < OP; c++) w = w | (mdl_cur[c] << (2 * c));
        return w;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("rst_ready", int'(cfg_ready), 0);
        chk("rst_addr", int'(AddressSelect), REST);
        chk("rst_cur", int'(cur_map), 6'h3F);
        for (int c = 0; c < OP; c++) mdl_cur[c] = NONE;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("rel_ready", int'(cfg_ready), 1);
        chk("rel_addr", int'(AddressSelect), REST);
        chk("rel_busy", int'(busy), 0);
        chk("rel_done", int'(cfg_done), 0);
    endtask

    // One full transaction; expectations come from the break-then-make rules.
    task automatic run_cfg(input logic [5:0] map, input bit hold_other, input string tag);
        int tgt [OP];
        int exp_q [$];
        int got_q [$];
        int s;
        int done_k;
        int w;
        bit prev_tog;
        for (int c = 0; c < OP; c++) begin
            tgt[c] = int'(map[2*c +: 2]);
            if (tgt[c] > NONE) tgt[c] = NONE;
        end
        for (int c = 0; c < OP; c++)
            if (mdl_cur[c] != NONE && mdl_cur[c] != tgt[c]) exp_q.push_back(mdl_cur[c] * OP + c);
        for (int c = 0; c < OP; c++)
            if (tgt[c] != NONE && mdl_cur[c] != tgt[c]) exp_q.push_back(tgt[c] * OP + c);
        s = 2 * OP + exp_q.size();

        w = 0;
        while (!cfg_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        chk({tag, "_ready"}, int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_map   = map;
        @(posedge Clk);
        #1;
        if (hold_other) cfg_map = ~map;
        else cfg_valid = 1'b0;

        done_k   = 0;
        prev_tog = 1'b0;
        for (int k = 1; k <= s + 3; k++) begin
            @(negedge Clk);
            chk({tag, "_busy"}, int'(busy), 1);
            if (prev_tog) chk({tag, "_gap"}, int'(AddressSelect), REST);
            prev_tog = (int'(AddressSelect) != REST);
            if (prev_tog) got_q.push_back(int'(AddressSelect));
            if (cfg_done) begin
                done_k = k;
                chk({tag, "_done_addr"}, int'(AddressSelect), REST);
                cfg_valid = 1'b0;
                break;
            end
        end
        cfg_valid = 1'b0;
        chk({tag, "_done_edge"}, done_k, s + 1);
        chk({tag, "_ntog"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk({tag, "_tog"}, got_q[i], exp_q[i]);

        for (int c = 0; c < OP; c++) mdl_cur[c] = tgt[c];
        @(negedge Clk);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_ready"}, int'(cfg_ready), 1);
        chk({tag, "_cur"}, int'(cur_map), mdl_word());
        chk({tag, "_xrej"}, xbar_rej, 0);
        for (int c = 0; c < OP; c++)
            chk({tag, "_xout"}, xbar_out(c), (tgt[c] == NONE) ? 0 : in_data(tgt[c]));
    endtask

    initial begin
        int w;
        Rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_map   = '0;

        apply_reset();
        for (int c = 0; c < OP; c++) chk("rst_xout", xbar_out(c), 0);

        run_cfg(6'h39, 1'b0, "s2");
        run_cfg(6'h3A, 1'b0, "s3");
        run_cfg(6'h3A, 1'b0, "s4");

        apply_reset();
        run_cfg(6'h00, 1'b1, "s5");
        chk("s5_cur_zero", int'(cur_map), 6'h00);

        // Reset one cycle after the first toggle of a sequence.
        apply_reset();
        @(negedge Clk);
        cfg_valid = 1'b1;
        cfg_map   = 6'h39;
        @(posedge Clk);
        #1;
        cfg_valid = 1'b0;
        w = 0;
        while (int'(AddressSelect) == REST && w < 20) begin
            @(negedge Clk);
            w++;
        end
        chk("s6_first_tog", int'(AddressSelect), 3);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("s6_addr", int'(AddressSelect), REST);
        chk("s6_cur", int'(cur_map), 6'h3F);
        chk("s6_busy", int'(busy), 0);
        for (int c = 0; c < OP; c++) mdl_cur[c] = NONE;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        run_cfg(6'h24, 1'b0, "s6b");

        for (int i = 0; i < 30; i++) begin
            logic [5:0] m;
            m = 6'($urandom_range(0, 63));
            run_cfg(m, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/xbar_route_sequencer.md
Name: xbar_route_sequencer

Overview:
Configuration controller for the parameterised crossbar.
- Accepts a complete routing map (one input selector per output) through a valid/ready handshake.
- Programs the crossbar by issuing single-cycle toggle addresses on its AddressSelect port, with the rest address between toggles.
- Keeps a shadow copy of the programmed connections. Always breaks stale connections before making new ones, so the crossbar's "column already claimed" guard never rejects a toggle.

Parameters:
IP_COUNT, 3, number of crossbar inputs (rows)
OP_COUNT, 3, number of crossbar outputs (columns)
REST_ADDR, IP_COUNT*OP_COUNT, no-op address driven when idle and between toggles
ADDR_WIDTH, $clog2(REST_ADDR+1), AddressSelect width; must be able to represent REST_ADDR
SEL_WIDTH, $clog2(IP_COUNT+1), width of one output's selector; value IP_COUNT = unconnected

Ports:
Clk  input  1  clock; rising edge
Rst  input  1  reset, asynchronous, active-high; shared with the crossbar
cfg_valid  input  1  requester presents a new map
cfg_ready  output  1  high only in IDLE and not in reset
cfg_map  input  OP_COUNT*SEL_WIDTH  target selector for output n at [n*SEL_WIDTH +: SEL_WIDTH]
cfg_done  output  1  one-cycle pulse when the map is fully applied
busy  output  1  high from accept until cfg_done inclusive
AddressSelect  output  ADDR_WIDTH  registered; drives the crossbar address port
cur_map  output  OP_COUNT*SEL_WIDTH  shadow of programmed connections, same encoding as cfg_map

Behaviour:
- Reset (async):
  - state=IDLE; AddressSelect=REST_ADDR; every cur_map field=IP_COUNT (none); cfg_done=0; busy=0; cfg_ready=0 while Rst is high.
  - Reset mid-sequence aborts the sequence immediately. The crossbar resets with it, so the shadow stays consistent.
- Accept: rising edge with cfg_valid && cfg_ready. cfg_map is latched into a target register and not sampled again. cfg_valid during busy is ignored.
- Target normalisation: any selector > IP_COUNT is treated as IP_COUNT (disconnect).
- Fan-out: one input may feed several outputs; each output has at most one input.
- FSM: IDLE -> BREAK_SCAN <-> BREAK_REST -> MAKE_SCAN <-> MAKE_REST -> DONE -> IDLE. A column counter col runs 0..OP_COUNT-1 in each phase.
- BREAK_SCAN, one cycle per column:
  - If cur[col] != none and cur[col] != tgt[col]: register AddressSelect = cur[col]*OP_COUNT + col, set cur[col] = none, go to BREAK_REST.
  - Otherwise keep AddressSelect = REST_ADDR and advance col.
- BREAK_REST: AddressSelect = REST_ADDR for exactly one cycle, then advance col.
- After the last column, go to MAKE_SCAN with col = 0.
- MAKE_SCAN / MAKE_REST: same structure.
  - Condition: tgt[col] != none and cur[col] != tgt[col].
  - Issued address: tgt[col]*OP_COUNT + col; cur[col] = tgt[col].
- Toggle visibility: every non-REST AddressSelect value is held for exactly one Clk cycle and is always followed by at least one REST_ADDR cycle, so the crossbar toggles each connection exactly once.
- Timing:
  - S = 2*OP_COUNT + N_toggle slot cycles, occupying the cycles that begin at edges 1..S after the accept edge.
  - cfg_done is high for the cycle beginning at edge S+1 (state DONE). The FSM then returns to IDLE and cfg_ready rises.
- AddressSelect is REST_ADDR whenever cfg_done is high, in IDLE, and in DONE.
- cur_map updates on the same edge that registers the corresponding toggle address.
- Arithmetic: address = sel*OP_COUNT + col, computed at ADDR_WIDTH. No overflow is possible because sel < IP_COUNT.

Test Plan (IP_COUNT=OP_COUNT=3, SEL_WIDTH=2, none=3, bench includes the crossbar plus a reference shadow model):
1. Rst pulse -> AddressSelect=9, cur_map=6'h3F, cfg_ready=1 the cycle after release; crossbar outputs all 0 with direct=0.
2. From reset, cfg_map={3,2,1} (out0<-in1, out1<-in2, out2 none) -> AddressSelect=3 for one cycle, then 9, then 7 for one cycle; cfg_done at edge 9 (S=8); cur_map=6'h39; crossbar out0=in1 data, out1=in2 data.
3. Then cfg_map={3,2,2} -> break address 3 issued before make address 6; cfg_done at edge 9; out0 now carries in2 data; no crossbar output holds stale in1 data after done.
4. Reapply the identical map -> AddressSelect stays 9 throughout; cfg_done at edge 7.
5. Fan-out cfg_map={0,0,0} from reset -> toggles 0, 1, 2 in order, each separated by 9; all three outputs carry in0 data. Hold cfg_valid high with a different map during busy -> ignored, and cur_map ends at 6'h00.
6. Assert Rst one cycle after the first toggle of scenario 2 -> AddressSelect=9 and cur_map=6'h3F immediately (no clock); busy=0. A fresh cfg then completes normally and matches the model.
